conv_udiv_29u_8u_seq: RTL

- Sequential radix-2 restoring unsigned divider: 29-bit dividend / 8-bit divisor -> 29-bit quotient + 8-bit remainder.
- Exact inverse of the conv core's 8u x 21u -> 29u multiplier. Used to undo scaled products, e.g. accumulator / kernel-count normalisation.
- Multi-cycle; one operation in flight; valid/ready handshake on both sides.

---
 rtl/conv_div_pkg.sv | 14 +
 rtl/conv_udiv_step.sv | 21 ++
 rtl/conv_udiv_29u_8u_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/conv_div_pkg.sv
// Shared constants and FSM encoding for the conv-core sequential unsigned divider.
package conv_div_pkg;

  localparam int DIVIDEND_W = 29;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_udiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module conv_udiv_step
  import conv_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] i_rem,
  input  logic                 i_msb,
  input  logic [DIVISOR_W-1:0] i_div,
  output logic [DIVISOR_W-1:0] o_rem,
  output logic                 o_q_bit
);

  logic [DIVISOR_W:0]   w_shifted;
  logic [DIVISOR_W-1:0] w_trial;

  assign w_shifted = {i_rem, i_msb};
  assign o_q_bit   = (w_shifted >= {1'b0, i_div});
  // When the divisor fits, the difference is below the divisor, so the low bits are exact.
  assign w_trial   = w_shifted[DIVISOR_W-1:0] - i_div;
  assign o_rem     = o_q_bit ? w_trial : w_shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/conv_udiv_29u_8u_seq.sv
// Sequential radix-2 restoring divider, 29u / 8u, one bit per cycle, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready only in IDLE, out_valid only in DONE.
module conv_udiv_29u_8u_seq
  import conv_div_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output state_t                dbg_state
);

  state_t                r_state;
  state_t                w_next_state;
  logic [DIVISOR_W-1:0]  r_div;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_dbz;
  logic [DIVISOR_W-1:0]  w_rem;
  logic                  w_q_bit;
  logic                  w_accept;
  logic [DIVIDEND_W-1:0] w_quo_next;

  conv_udiv_step u_step (
    .i_rem   (r_rem),
    .i_msb   (r_quo[DIVIDEND_W-1]),
    .i_div   (r_div),
    .o_rem   (w_rem),
    .o_q_bit (w_q_bit)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_quo_next = {r_quo[DIVIDEND_W-2:0], w_q_bit};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath; result registers are written only on the edge that enters DONE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_div       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        if (divisor != '0) begin
          r_div <= divisor;
          r_quo <= dividend;
          r_rem <= '0;
          r_cnt <= CNT_W'(DIVIDEND_W - 1);
        end else begin
          r_quotient  <= '1;
          r_remainder <= '0;
          r_dbz       <= 1'b1;
        end
      end else if (r_state == CALC) begin
        r_rem <= w_rem;
        r_quo <= w_quo_next;
        if (r_cnt == '0) begin
          r_quotient  <= w_quo_next;
          r_remainder <= w_rem;
          r_dbz       <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule
